// File: rtl/tdp_bram_pkg.sv
// Shared constants and helpers for the byte-enabled true dual-port RAM.
// No logic; no latency.
// No backpressure; definitions only.
package tdp_bram_pkg;

    localparam int RDW_READ_FIRST  = 0;
    localparam int RDW_WRITE_FIRST = 1;
    localparam int RDW_NO_CHANGE   = 2;

    // Number of write-mask lanes in one word.
    function automatic int nb(input int data_w, input int byte_w);
        return data_w / byte_w;
    endfunction

endpackage

// File: rtl/tdp_bram_rdpipe.sv
// Per-port read return path: optional output register, dvalid shift, NO_CHANGE hold.
// Latency: 0 cycles after the RAM data register (1 with OUT_REG), tracking the RAM stage.
// No backpressure; the pipe advances every cycle and rst flushes it.
module tdp_bram_rdpipe #(
    parameter int DATA_W  = 32,
    parameter int OUT_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              acc_en,
    input  logic              hold_req,
    input  logic [DATA_W-1:0] rd_dat,
    output logic [DATA_W-1:0] dout,
    output logic              dvalid
);

    logic              v1;
    logic              h1;
    logic [DATA_W-1:0] held_q;
    logic [DATA_W-1:0] nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0;
            h1 <= 1'b0;
        end else begin
            v1 <= acc_en;
            h1 <= acc_en & hold_req;
        end
    end

    // A held access still reports valid but leaves the visible word untouched.
    assign nxt = (v1 && !h1) ? rd_dat : held_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            held_q <= '0;
        end else begin
            held_q <= nxt;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_oreg
            logic vld_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    vld_q <= 1'b0;
                end else begin
                    vld_q <= v1;
                end
            end
            assign dout   = held_q;
            assign dvalid = vld_q;
        end else begin : g_noreg
            assign dout   = nxt;
            assign dvalid = v1;
        end
    endgenerate

endmodule

// File: rtl/tdp_bram_be_pipe.sv
// True dual-port byte-enabled block RAM with collision detect and saturating collision count.
// Latency: 1+OUT_REG cycles from enabled access to dout/dvalid and coll_pulse.
// No backpressure; every enabled access is accepted, there is no stall.
module tdp_bram_be_pipe
    import tdp_bram_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 14,
    parameter int BYTE_W   = 8,
    parameter int RDW_MODE = 0,
    parameter int OUT_REG  = 1,
    parameter int CNT_W    = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              en_a,
    input  logic [nb(DATA_W, BYTE_W)-1:0]     we_a,
    input  logic [ADDR_W-1:0]                 addr_a,
    input  logic [DATA_W-1:0]                 din_a,
    output logic [DATA_W-1:0]                 dout_a,
    output logic                              dvalid_a,
    input  logic                              en_b,
    input  logic [nb(DATA_W, BYTE_W)-1:0]     we_b,
    input  logic [ADDR_W-1:0]                 addr_b,
    input  logic [DATA_W-1:0]                 din_b,
    output logic [DATA_W-1:0]                 dout_b,
    output logic                              dvalid_b,
    output logic                              coll_pulse,
    output logic [CNT_W-1:0]                  coll_cnt,
    input  logic                              coll_clr
);

    localparam int NB    = nb(DATA_W, BYTE_W);
    localparam int DEPTH = 1 << ADDR_W;

    generate
        if (DATA_W % BYTE_W != 0) begin : g_bad_width
            $fatal(1, "tdp_bram_be_pipe: DATA_W must be a multiple of BYTE_W");
        end
        if (RDW_MODE > 2) begin : g_bad_mode
            $fatal(1, "tdp_bram_be_pipe: RDW_MODE must be 0, 1 or 2");
        end
    endgenerate

    (* ram_style = "block" *) logic [DATA_W-1:0] mem [DEPTH];

    logic [DATA_W-1:0] merged_a;
    logic [DATA_W-1:0] merged_b;
    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;
    logic              hold_a;
    logic              hold_b;
    logic              coll_now;
    logic              coll_s1;
    logic              coll_s2;

    // Port A is written after port B so that A owns every lane both ports mask in.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NB; i++) begin
                if (en_b && we_b[i]) begin
                    mem[addr_b][i*BYTE_W +: BYTE_W] <= din_b[i*BYTE_W +: BYTE_W];
                end
                if (en_a && we_a[i]) begin
                    mem[addr_a][i*BYTE_W +: BYTE_W] <= din_a[i*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    // Write-first view only merges the port's own lanes; the other port's write stays invisible.
    always_comb begin
        merged_a = mem[addr_a];
        merged_b = mem[addr_b];
        for (int i = 0; i < NB; i++) begin
            if (we_a[i]) begin
                merged_a[i*BYTE_W +: BYTE_W] = din_a[i*BYTE_W +: BYTE_W];
            end
            if (we_b[i]) begin
                merged_b[i*BYTE_W +: BYTE_W] = din_b[i*BYTE_W +: BYTE_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (en_a) begin
            rd_a <= (RDW_MODE == RDW_WRITE_FIRST) ? merged_a : mem[addr_a];
        end
        if (en_b) begin
            rd_b <= (RDW_MODE == RDW_WRITE_FIRST) ? merged_b : mem[addr_b];
        end
    end

    assign hold_a = (RDW_MODE == RDW_NO_CHANGE) && (|we_a);
    assign hold_b = (RDW_MODE == RDW_NO_CHANGE) && (|we_b);

    tdp_bram_rdpipe #(
        .DATA_W  (DATA_W),
        .OUT_REG (OUT_REG)
    ) u_rdpipe_a (
        .clk      (clk),
        .rst      (rst),
        .acc_en   (en_a),
        .hold_req (hold_a),
        .rd_dat   (rd_a),
        .dout     (dout_a),
        .dvalid   (dvalid_a)
    );

    tdp_bram_rdpipe #(
        .DATA_W  (DATA_W),
        .OUT_REG (OUT_REG)
    ) u_rdpipe_b (
        .clk      (clk),
        .rst      (rst),
        .acc_en   (en_b),
        .hold_req (hold_b),
        .rd_dat   (rd_b),
        .dout     (dout_b),
        .dvalid   (dvalid_b)
    );

    assign coll_now = en_a && en_b && (addr_a == addr_b) && (|(we_a & we_b));

    // Delay the detect so the pulse lines up with the dvalid of the colliding accesses.
    always_ff @(posedge clk) begin
        if (rst) begin
            coll_s1 <= 1'b0;
            coll_s2 <= 1'b0;
        end else begin
            coll_s1 <= coll_now;
            coll_s2 <= coll_s1;
        end
    end

    assign coll_pulse = (OUT_REG != 0) ? coll_s2 : coll_s1;

    always_ff @(posedge clk) begin
        if (rst) begin
            coll_cnt <= '0;
        end else if (coll_clr) begin
            coll_cnt <= '0;
        end else if (coll_pulse && (coll_cnt != {CNT_W{1'b1}})) begin
            coll_cnt <= coll_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_tdp_bram_be_pipe.sv
// Scoreboard bench: three RAMs (READ_FIRST / WRITE_FIRST / NO_CHANGE) share one stimulus stream.
// Latency 2 expected everywhere; no backpressure exists on the DUT.
// Checks data, dvalid timing, collision pulses, counter saturation/clear and reset flush.
module tb_tdp_bram_be_pipe;

    typedef struct {
        logic [2:0]  care;
        logic [31:0] d [3];
        int          due;
    } exp_t;

    typedef struct {
        int          due;
        bit          zero_out;
        logic [15:0] cnt [3];
    } st_t;

    logic        clk;
    logic        rst;
    logic        en_a, en_b, coll_clr;
    logic [3:0]  we_a, we_b;
    logic [13:0] addr_a, addr_b;
    logic [31:0] din_a, din_b;
    logic [31:0] dout_a [3];
    logic [31:0] dout_b [3];
    logic        dvalid_a [3];
    logic        dvalid_b [3];
    logic        coll_pulse [3];
    logic [1:0]  cnt0;
    logic [15:0] cnt1, cnt2;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   no_push = 0;
    bit   done = 0;
    exp_t qa[$];
    exp_t qb[$];
    int   qc[$];
    st_t  qs[$];
    exp_t none_e;

    tdp_bram_be_pipe #(.RDW_MODE(0), .OUT_REG(1), .CNT_W(2)) u0 (
        .clk(clk), .rst(rst),
        .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .din_a(din_a), .dout_a(dout_a[0]), .dvalid_a(dvalid_a[0]),
        .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .din_b(din_b), .dout_b(dout_b[0]), .dvalid_b(dvalid_b[0]),
        .coll_pulse(coll_pulse[0]), .coll_cnt(cnt0), .coll_clr(coll_clr)
    );

    tdp_bram_be_pipe #(.RDW_MODE(1), .OUT_REG(1), .CNT_W(16)) u1 (
        .clk(clk), .rst(rst),
        .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .din_a(din_a), .dout_a(dout_a[1]), .dvalid_a(dvalid_a[1]),
        .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .din_b(din_b), .dout_b(dout_b[1]), .dvalid_b(dvalid_b[1]),
        .coll_pulse(coll_pulse[1]), .coll_cnt(cnt1), .coll_clr(coll_clr)
    );

    tdp_bram_be_pipe #(.RDW_MODE(2), .OUT_REG(1), .CNT_W(16)) u2 (
        .clk(clk), .rst(rst),
        .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .din_a(din_a), .dout_a(dout_a[2]), .dvalid_a(dvalid_a[2]),
        .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .din_b(din_b), .dout_b(dout_b[2]), .dvalid_b(dvalid_b[2]),
        .coll_pulse(coll_pulse[2]), .coll_cnt(cnt2), .coll_clr(coll_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t ex(input logic [2:0] c, input logic [31:0] d0, input logic [31:0] d1,
                                input logic [31:0] d2);
        exp_t e;
        e.care = c;
        e.d[0] = d0;
        e.d[1] = d1;
        e.d[2] = d2;
        e.due  = 0;
        return e;
    endfunction

    function automatic exp_t all3(input logic [31:0] d);
        return ex(3'b111, d, d, d);
    endfunction

    // One stimulus slot: inputs applied after a falling edge, sampled at the next rising edge.
    task automatic drive(input logic ea, input logic [3:0] wa, input logic [13:0] aa, input logic [31:0] da,
                         input exp_t xa,
                         input logic eb, input logic [3:0] wb, input logic [13:0] ab, input logic [31:0] db,
                         input exp_t xb, input logic coll);
        en_a = ea; we_a = wa; addr_a = aa; din_a = da;
        en_b = eb; we_b = wb; addr_b = ab; din_b = db;
        if (!no_push) begin
            if (ea) begin
                xa.due = cyc + 2;
                qa.push_back(xa);
            end
            if (eb) begin
                xb.due = cyc + 2;
                qb.push_back(xb);
            end
            if (coll) qc.push_back(cyc + 2);
        end
        @(negedge clk);
    endtask

    task automatic a_only(input logic [3:0] w, input logic [13:0] ad, input logic [31:0] d, input exp_t x);
        drive(1'b1, w, ad, d, x, 1'b0, 4'h0, 14'h0, 32'h0, none_e, 1'b0);
    endtask

    task automatic b_only(input logic [3:0] w, input logic [13:0] ad, input logic [31:0] d, input exp_t x);
        drive(1'b0, 4'h0, 14'h0, 32'h0, none_e, 1'b1, w, ad, d, x, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 4'h0, 14'h0, 32'h0, none_e, 1'b0, 4'h0, 14'h0, 32'h0, none_e, 1'b0);
        end
    endtask

    task automatic st_expect(input bit z, input logic [15:0] c0, input logic [15:0] c1, input logic [15:0] c2);
        st_t s;
        s.due      = cyc + 1;
        s.zero_out = z;
        s.cnt[0]   = c0;
        s.cnt[1]   = c1;
        s.cnt[2]   = c2;
        qs.push_back(s);
    endtask

    task automatic cmp(input string nm, input int m, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s dut%0d cyc=%0d got=%h exp=%h", nm, m, cyc, got, exp);
        end
    endtask

    // Monitor: the only process that compares and counts.
    initial begin
        exp_t e;
        st_t  s;
        bit   ev;
        forever begin
            @(negedge clk);
            ev = (qa.size() != 0) && (qa[0].due == cyc);
            if (ev || dvalid_a[0] || dvalid_a[1] || dvalid_a[2]) begin
                if (ev) e = qa.pop_front();
                for (int m = 0; m < 3; m++) begin
                    cmp("dvalid_a", m, {31'b0, dvalid_a[m]}, {31'b0, ev});
                    if (ev && e.care[m]) cmp("dout_a", m, dout_a[m], e.d[m]);
                end
            end
            ev = (qb.size() != 0) && (qb[0].due == cyc);
            if (ev || dvalid_b[0] || dvalid_b[1] || dvalid_b[2]) begin
                if (ev) e = qb.pop_front();
                for (int m = 0; m < 3; m++) begin
                    cmp("dvalid_b", m, {31'b0, dvalid_b[m]}, {31'b0, ev});
                    if (ev && e.care[m]) cmp("dout_b", m, dout_b[m], e.d[m]);
                end
            end
            ev = (qc.size() != 0) && (qc[0] == cyc);
            if (ev || coll_pulse[0] || coll_pulse[1] || coll_pulse[2]) begin
                if (ev) void'(qc.pop_front());
                for (int m = 0; m < 3; m++) cmp("coll_pulse", m, {31'b0, coll_pulse[m]}, {31'b0, ev});
            end
            if ((qs.size() != 0) && (qs[0].due == cyc)) begin
                s = qs.pop_front();
                cmp("coll_cnt", 0, {30'b0, cnt0}, {16'b0, s.cnt[0]});
                cmp("coll_cnt", 1, {16'b0, cnt1}, {16'b0, s.cnt[1]});
                cmp("coll_cnt", 2, {16'b0, cnt2}, {16'b0, s.cnt[2]});
                if (s.zero_out) begin
                    for (int m = 0; m < 3; m++) begin
                        cmp("rst_dout_a", m, dout_a[m], 32'h0);
                        cmp("rst_dout_b", m, dout_b[m], 32'h0);
                        cmp("rst_valid", m, {30'b0, dvalid_a[m], dvalid_b[m]}, 32'h0);
                    end
                end
            end
            if (cyc > 3000) begin
                checks++;
                errors++;
                $display("FAIL timeout cyc=%0d", cyc);
                break;
            end
            if (done) break;
        end
        cmp("qa_left", 0, qa.size(), 32'h0);
        cmp("qb_left", 0, qb.size(), 32'h0);
        cmp("qc_left", 0, qc.size(), 32'h0);
        cmp("qs_left", 0, qs.size(), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        none_e   = ex(3'b000, 32'h0, 32'h0, 32'h0);
        rst      = 1'b1;
        coll_clr = 1'b0;
        en_a = 1'b0; we_a = 4'h0; addr_a = 14'h0; din_a = 32'h0;
        en_b = 1'b0; we_b = 4'h0; addr_b = 14'h0; din_b = 32'h0;
        idle(3);
        st_expect(1'b1, 16'd0, 16'd0, 16'd0);
        idle(1);
        rst = 1'b0;

        // Write then cross-port read, two-cycle latency
        a_only(4'hF, 14'h0010, 32'hDEADBEEF, ex(3'b110, 32'h0, 32'hDEADBEEF, 32'h0));
        b_only(4'h0, 14'h0010, 32'h0, all3(32'hDEADBEEF));

        // Byte-masked write
        a_only(4'hF, 14'h0005, 32'h11223344, ex(3'b110, 32'h0, 32'h11223344, 32'h0));
        a_only(4'b0101, 14'h0005, 32'hAABBCCDD, ex(3'b111, 32'h11223344, 32'h11BB33DD, 32'h0));
        a_only(4'h0, 14'h0005, 32'h0, all3(32'h11BB33DD));

        // Same-port read-during-write per mode
        a_only(4'hF, 14'h0020, 32'h12345678, ex(3'b110, 32'h0, 32'h12345678, 32'h11BB33DD));
        a_only(4'hF, 14'h0020, 32'hCAFEF00D, ex(3'b111, 32'h12345678, 32'hCAFEF00D, 32'h11BB33DD));
        b_only(4'h0, 14'h0020, 32'h0, all3(32'hCAFEF00D));

        // Cross-port reader sees the pre-write word in every mode
        drive(1'b1, 4'hF, 14'h0020, 32'h55AA55AA, ex(3'b111, 32'hCAFEF00D, 32'h55AA55AA, 32'h11BB33DD),
              1'b1, 4'h0, 14'h0020, 32'h0, all3(32'hCAFEF00D), 1'b0);

        // Dual write collision: A owns overlapping lanes
        a_only(4'hF, 14'h0007, 32'h01020304, ex(3'b110, 32'h0, 32'h01020304, 32'h11BB33DD));
        drive(1'b1, 4'hF, 14'h0007, 32'hAAAAAAAA, ex(3'b111, 32'h01020304, 32'hAAAAAAAA, 32'h11BB33DD),
              1'b1, 4'b0011, 14'h0007, 32'hBBBBBBBB, ex(3'b111, 32'h01020304, 32'h0102BBBB, 32'hCAFEF00D), 1'b1);
        b_only(4'h0, 14'h0007, 32'h0, all3(32'hAAAAAAAA));
        idle(3);
        st_expect(1'b0, 16'd1, 16'd1, 16'd1);
        idle(1);

        // Disjoint masks at one address: both land, no collision
        drive(1'b1, 4'b1100, 14'h0008, 32'h11112222, ex(3'b100, 32'h0, 32'h0, 32'h11BB33DD),
              1'b1, 4'b0011, 14'h0008, 32'h33334444, ex(3'b100, 32'h0, 32'h0, 32'hAAAAAAAA), 1'b0);
        b_only(4'h0, 14'h0008, 32'h0, all3(32'h11114444));

        // Five back-to-back collisions: 2-bit counter saturates at 3
        a_only(4'hF, 14'h0009, 32'h0, ex(3'b110, 32'h0, 32'h0, 32'h11BB33DD));
        drive(1'b1, 4'b0001, 14'h0009, 32'h000000A5, ex(3'b111, 32'h0, 32'h000000A5, 32'h11BB33DD),
              1'b1, 4'b0001, 14'h0009, 32'h0000005A, ex(3'b111, 32'h0, 32'h0000005A, 32'h11114444), 1'b1);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 4'b0001, 14'h0009, 32'h000000A5,
                  ex(3'b111, 32'h000000A5, 32'h000000A5, 32'h11BB33DD),
                  1'b1, 4'b0001, 14'h0009, 32'h0000005A,
                  ex(3'b111, 32'h000000A5, 32'h0000005A, 32'h11114444), 1'b1);
        end
        b_only(4'h0, 14'h0009, 32'h0, all3(32'h000000A5));
        idle(3);
        st_expect(1'b0, 16'd3, 16'd6, 16'd6);
        idle(1);

        // Clear coinciding with a collision pulse: clear wins
        drive(1'b1, 4'b0001, 14'h0009, 32'h000000A5, ex(3'b111, 32'h000000A5, 32'h000000A5, 32'h11BB33DD),
              1'b1, 4'b0001, 14'h0009, 32'h0000005A, ex(3'b111, 32'h000000A5, 32'h0000005A, 32'h000000A5), 1'b1);
        idle(1);
        coll_clr = 1'b1;
        idle(1);
        coll_clr = 1'b0;
        idle(2);
        st_expect(1'b0, 16'd0, 16'd0, 16'd0);
        idle(1);

        // Reset with reads in flight and a write/collision in the reset cycle
        no_push = 1'b1;
        drive(1'b1, 4'h0, 14'h0005, 32'h0, none_e, 1'b1, 4'h0, 14'h0010, 32'h0, none_e, 1'b0);
        rst = 1'b1;
        drive(1'b1, 4'hF, 14'h0005, 32'hFFFFFFFF, none_e, 1'b1, 4'hF, 14'h0005, 32'hEEEEEEEE, none_e, 1'b1);
        idle(2);
        st_expect(1'b1, 16'd0, 16'd0, 16'd0);
        idle(1);
        rst = 1'b0;
        no_push = 1'b0;
        idle(2);
        b_only(4'h0, 14'h0005, 32'h0, all3(32'h11BB33DD));
        a_only(4'h0, 14'h0010, 32'h0, all3(32'hDEADBEEF));
        idle(4);
        done = 1'b1;
    end

endmodule
